// File: rtl/key_mode_pkg.sv
// rtl/key_mode_pkg.sv - shared state, event and counter definitions for key_mode_ctrl
package key_mode_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_IDLE,
    ST_PRESS,
    ST_LONG_HELD,
    ST_WAIT2,
    ST_PRESS2
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_SHORT,
    EV_LONG,
    EV_DBL
  } event_t;

endpackage

// File: rtl/key_mode_edge.sv
// rtl/key_mode_edge.sv - two-flop edge stage producing press/release strobes from key_n
module key_mode_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_lvl,
  output logic key_press,
  output logic key_release
);

  logic key_r;
  logic key_rr;

  // Reset to 0 so a key held low through reset never looks like a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r  <= 1'b0;
      key_rr <= 1'b0;
    end else begin
      key_r  <= key_n;
      key_rr <= key_r;
    end
  end

  assign key_lvl     = key_r;
  assign key_press   = key_rr & ~key_r;
  assign key_release = ~key_rr & key_r;

endmodule

// File: rtl/key_mode_ctrl.sv
// rtl/key_mode_ctrl.sv - key press classifier (short/long/double) and wrapping mode selector
// Double-click detection is built only when KEY_MODE_DBLCLK_EN is defined.
module key_mode_ctrl
  import key_mode_pkg::*;
#(
  parameter logic [CNT_W-1:0] LONG_CNT = 32'd50000000,
  parameter logic [CNT_W-1:0] DCLK_CNT = 32'd12500000,
  parameter int               MODE_NUM = 4,
  parameter int               MODE_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_n,
  output logic              short_pulse,
  output logic              long_pulse,
  output logic              dbl_pulse,
  output logic [MODE_W-1:0] mode_idx,
  output logic              mode_chg,
  output logic              busy
);

  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(MODE_NUM - 1);

  if (LONG_CNT < 2 || DCLK_CNT < 2 || MODE_NUM < 2 || MODE_NUM > (2 ** MODE_W)) begin : g_param_err
    $error("key_mode_ctrl: illegal parameter combination");
  end

  logic             key_r;
  logic             key_press;
  logic             key_release;
  state_t           state;
  state_t           state_nxt;
  event_t           ev_nxt;
  logic [CNT_W-1:0] cnt;
  logic             counting;

  key_mode_edge u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .key_lvl    (key_r),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always_comb begin
    state_nxt = state;
    ev_nxt    = EV_NONE;
    case (state)
      ST_ARM: begin
        if (key_r) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (key_press) state_nxt = ST_PRESS;
      end
      ST_PRESS: begin
        // The long threshold wins over a release landing in the same cycle.
        if (cnt == LONG_CNT - CNT_W'(1)) begin
          ev_nxt    = EV_LONG;
          state_nxt = ST_LONG_HELD;
        end else if (key_release) begin
`ifdef KEY_MODE_DBLCLK_EN
          state_nxt = ST_WAIT2;
`else
          ev_nxt    = EV_SHORT;
          state_nxt = ST_IDLE;
`endif
        end
      end
      ST_LONG_HELD: begin
        if (key_r) state_nxt = ST_IDLE;
      end
`ifdef KEY_MODE_DBLCLK_EN
      ST_WAIT2: begin
        if (key_press) begin
          state_nxt = ST_PRESS2;
        end else if (cnt == DCLK_CNT - CNT_W'(1)) begin
          ev_nxt    = EV_SHORT;
          state_nxt = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        // A second click held long becomes a plain long press; the first click is dropped.
        if (cnt == LONG_CNT - CNT_W'(1)) begin
          ev_nxt    = EV_LONG;
          state_nxt = ST_LONG_HELD;
        end else if (key_release) begin
          ev_nxt    = EV_DBL;
          state_nxt = ST_IDLE;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign counting = (state == ST_PRESS) || (state == ST_PRESS2) || (state == ST_WAIT2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ARM;
      cnt         <= '0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
    end else begin
      state       <= state_nxt;
      short_pulse <= (ev_nxt == EV_SHORT);
      long_pulse  <= (ev_nxt == EV_LONG);
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (counting) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef KEY_MODE_DBLCLK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbl_pulse <= 1'b0;
    end else begin
      dbl_pulse <= (ev_nxt == EV_DBL);
    end
  end
`else
  assign dbl_pulse = 1'b0;
`endif

  // Mode follows the event pulse by one edge; a long press always re-announces mode 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_idx <= '0;
      mode_chg <= 1'b0;
    end else begin
      mode_chg <= short_pulse | long_pulse | dbl_pulse;
      if (long_pulse) begin
        mode_idx <= '0;
      end else if (short_pulse) begin
        mode_idx <= (mode_idx == MODE_MAX) ? '0 : mode_idx + MODE_W'(1);
      end else if (dbl_pulse) begin
        mode_idx <= (mode_idx == '0) ? MODE_MAX : mode_idx - MODE_W'(1);
      end
    end
  end

  assign busy = (state != ST_ARM) && (state != ST_IDLE);

endmodule
